log_compare_reduce: RTL and testbench

Streaming, multi-lane min/max reducer over log-domain numbers with argmin/argmax index output. Accepts LANES packed log numbers per beat over a valid/ready handshake. Reduces each vector, delimited by `in_last`, to one extreme value plus the position where it first occurs. It reuses the existing `LogCompare` / `LogNumberToLogNumberUnpacked` semantics for ordering and infinity, and is the sequential successor to the single-pair combinational comparator.

---
 rtl/log_compare_reduce_pkg.sv | 26 ++
 rtl/log_compare_reduce_lane_tree.sv | 81 ++++++++
 rtl/log_compare_reduce.sv | 247 ++++++++++++++++++++++++
 tb/tb_log_compare_reduce.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/log_compare_reduce_pkg.sv
// Shared types and width helpers for the streaming log-domain min/max reducer.
package log_compare_reduce_pkg;

    typedef enum logic [0:0] {
        OP_MAX = 1'b0,
        OP_MIN = 1'b1
    } reduce_op_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    function automatic int log_width(input int m, input int f);
        return m + f + 32'sd1;
    endfunction

    function automatic int beat_cnt_width(input int idx_bits, input int lanes);
        return idx_bits - $clog2(lanes);
    endfunction

    function automatic int lane_width(input int lanes);
        return (lanes > 32'sd1) ? $clog2(lanes) : 32'sd1;
    endfunction

endpackage

// File: rtl/log_compare_reduce_lane_tree.sv
// Combinational reduction of one beat's unmasked lanes to a single extreme value.
// Log numbers are {sign, signed log2 magnitude}; most-negative log = zero, most-positive log = inf.
module log_compare_reduce_lane_tree
    import log_compare_reduce_pkg::*;
#(
    parameter int M     = 2,
    parameter int F     = 4,
    parameter int LANES = 4,
    localparam int W    = log_width(M, F),
    localparam int LW   = lane_width(LANES)
)(
    input  reduce_op_t           op,
    input  logic [LANES*W-1:0]   in_data,
    input  logic [LANES-1:0]     in_lane_valid,
    output logic [W-1:0]         out_value,
    output logic [LW-1:0]        out_lane,
    output logic                 out_any_valid,
    output logic                 out_any_inf
);
    localparam int L     = M + F;
    localparam int NODES = 2 * LANES - 1;

    function automatic logic is_inf(input logic [W-1:0] v);
        return v[L-1:0] == {1'b0, {(L-1){1'b1}}};
    endfunction

    function automatic logic is_zero(input logic [W-1:0] v);
        return v[L-1:0] == {1'b1, {(L-1){1'b0}}};
    endfunction

    // Strict a > b on finite values; any comparison involving inf is false.
    function automatic logic log_gt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [L-1:0] la;
        logic signed [L-1:0] lb;
        logic gt;
        la = a[L-1:0];
        lb = b[L-1:0];
        if (is_inf(a) || is_inf(b))      gt = 1'b0;
        else if (is_zero(a) && is_zero(b)) gt = 1'b0;
        else if (is_zero(a))             gt = b[W-1];
        else if (is_zero(b))             gt = !a[W-1];
        else if (a[W-1] != b[W-1])       gt = !a[W-1];
        else if (!a[W-1])                gt = la > lb;
        else                             gt = la < lb;
        return gt;
    endfunction

    logic [W-1:0]  val_s  [NODES];
    logic [LW-1:0] lane_s [NODES];
    logic          vld_s  [NODES];
    logic          inf_s  [NODES];
    logic          take_s;
    logic          better_s;

    // Heap-ordered tree: leaves at LANES-1+k, left child always holds the lower lanes.
    always_comb begin
        take_s   = 1'b0;
        better_s = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            val_s[LANES-1+k]  = in_data[k*W +: W];
            lane_s[LANES-1+k] = LW'(k);
            vld_s[LANES-1+k]  = in_lane_valid[k];
            inf_s[LANES-1+k]  = in_lane_valid[k] & is_inf(in_data[k*W +: W]);
        end
        for (int n = LANES - 2; n >= 0; n--) begin
            better_s = (op == OP_MAX) ? log_gt(val_s[2*n+2], val_s[2*n+1])
                                      : log_gt(val_s[2*n+1], val_s[2*n+2]);
            take_s   = vld_s[2*n+2] &&
                       (!vld_s[2*n+1] || (!inf_s[2*n+1] && (inf_s[2*n+2] || better_s)));
            val_s[n]  = take_s ? val_s[2*n+2]  : val_s[2*n+1];
            lane_s[n] = take_s ? lane_s[2*n+2] : lane_s[2*n+1];
            vld_s[n]  = vld_s[2*n+1] | vld_s[2*n+2];
            inf_s[n]  = inf_s[2*n+1] | inf_s[2*n+2];
        end
        out_value     = val_s[0];
        out_lane      = lane_s[0];
        out_any_valid = vld_s[0];
        out_any_inf   = inf_s[0];
    end

endmodule

// File: rtl/log_compare_reduce.sv
// Streaming multi-lane min/max reducer with argmin/argmax: input register, lane-tree
// register, then an accumulator that writes the result register on the last beat.
module log_compare_reduce
    import log_compare_reduce_pkg::*;
#(
    parameter int M        = 2,
    parameter int F        = 4,
    parameter int LANES    = 4,
    parameter int IDX_BITS = 16,
    localparam int W       = log_width(M, F)
)(
    input  logic                  clock,
    input  logic                  reset,
    input  reduce_op_t            op,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*W-1:0]    in_data,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic [IDX_BITS-1:0]   out_index,
    output logic                  out_inf,
    output logic                  out_empty,
    output logic                  out_overflow
);
    localparam int CW    = beat_cnt_width(IDX_BITS, LANES);
    localparam int LW    = lane_width(LANES);
    localparam int LOG2L = $clog2(LANES);

    logic accept_s, step_s;
    reduce_op_t op_in_s;
    logic in_first_r, wrapped_r;
    reduce_op_t op_hold_r;
    logic [CW-1:0] cnt_r;

    logic p0_valid_r, p0_last_r, p0_ovf_r;
    logic [LANES*W-1:0] p0_data_r;
    logic [LANES-1:0] p0_mask_r;
    reduce_op_t p0_op_r;
    logic [CW-1:0] p0_beat_r;

    logic [W-1:0] t_val_s;
    logic [LW-1:0] t_lane_s;
    logic t_vld_s, t_inf_s;

    logic s1_valid_r, s1_last_r, s1_vld_r, s1_inf_r, s1_ovf_r;
    logic [W-1:0] s1_val_r;
    logic [IDX_BITS-1:0] s1_idx_r;
    reduce_op_t s1_op_r;

    acc_state_t state_r, state_nx_s;
    logic acc_vld_r, acc_inf_r, acc_ovf_r;
    logic [W-1:0] acc_val_r;
    logic [IDX_BITS-1:0] acc_idx_r;
    reduce_op_t acc_op_r;

    logic [W-1:0] m_val_s;
    logic [0:0] m_lane_s;
    logic m_vld_s, m_inf_s;

    logic [W-1:0] res_val_s;
    logic [IDX_BITS-1:0] res_idx_s;
    logic res_vld_s, res_inf_s, res_ovf_s;
    reduce_op_t res_op_s;

    // A held result stalls the entire pipeline.
    assign in_ready = !(out_valid && !out_ready);
    assign accept_s = in_valid && in_ready;
    assign step_s   = in_ready && s1_valid_r;
    assign op_in_s  = in_first_r ? op : op_hold_r;

    // Vector framing at the input: latched op, beat counter and sticky wrap flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_first_r <= 1'b1;
            op_hold_r  <= OP_MAX;
            cnt_r      <= {CW{1'b0}};
            wrapped_r  <= 1'b0;
        end else if (accept_s) begin
            op_hold_r <= op_in_s;
            if (in_last) begin
                in_first_r <= 1'b1;
                cnt_r      <= {CW{1'b0}};
                wrapped_r  <= 1'b0;
            end else begin
                in_first_r <= 1'b0;
                cnt_r      <= cnt_r + 1'b1;
                wrapped_r  <= wrapped_r | (&cnt_r);
            end
        end
    end

    // Input pipeline register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p0_valid_r <= 1'b0;
            p0_last_r  <= 1'b0;
            p0_ovf_r   <= 1'b0;
            p0_data_r  <= {(LANES*W){1'b0}};
            p0_mask_r  <= {LANES{1'b0}};
            p0_op_r    <= OP_MAX;
            p0_beat_r  <= {CW{1'b0}};
        end else if (in_ready) begin
            p0_valid_r <= in_valid;
            p0_last_r  <= in_last;
            p0_ovf_r   <= wrapped_r;
            p0_data_r  <= in_data;
            p0_mask_r  <= in_lane_valid;
            p0_op_r    <= op_in_s;
            p0_beat_r  <= cnt_r;
        end
    end

    log_compare_reduce_lane_tree #(.M(M), .F(F), .LANES(LANES)) u_lane_tree (
        .op            (p0_op_r),
        .in_data       (p0_data_r),
        .in_lane_valid (p0_mask_r),
        .out_value     (t_val_s),
        .out_lane      (t_lane_s),
        .out_any_valid (t_vld_s),
        .out_any_inf   (t_inf_s)
    );

    // Lane-tree result register; index is beat*LANES + lane, wrapping naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_vld_r   <= 1'b0;
            s1_inf_r   <= 1'b0;
            s1_ovf_r   <= 1'b0;
            s1_val_r   <= {W{1'b0}};
            s1_idx_r   <= {IDX_BITS{1'b0}};
            s1_op_r    <= OP_MAX;
        end else if (in_ready) begin
            s1_valid_r <= p0_valid_r;
            s1_last_r  <= p0_last_r;
            s1_vld_r   <= t_vld_s;
            s1_inf_r   <= t_inf_s;
            s1_ovf_r   <= p0_ovf_r;
            s1_val_r   <= t_val_s;
            s1_idx_r   <= (IDX_BITS'(p0_beat_r) << LOG2L) | IDX_BITS'(t_lane_s);
            s1_op_r    <= p0_op_r;
        end
    end

    // Accumulator in lane 0 so it keeps ties against the incoming beat.
    log_compare_reduce_lane_tree #(.M(M), .F(F), .LANES(2)) u_merge (
        .op            (acc_op_r),
        .in_data       ({s1_val_r, acc_val_r}),
        .in_lane_valid ({s1_vld_r, acc_vld_r}),
        .out_value     (m_val_s),
        .out_lane      (m_lane_s),
        .out_any_valid (m_vld_s),
        .out_any_inf   (m_inf_s)
    );

    // Accumulator state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nx_s;
    end

    // Accumulator next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  state_nx_s = (step_s && !s1_last_r) ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: state_nx_s = (step_s && s1_last_r) ? ST_IDLE : ST_ACCUM;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // First beat loads straight from the lane tree; later beats take the merge.
    always_comb begin
        res_val_s = s1_val_r;
        res_idx_s = s1_idx_r;
        res_vld_s = s1_vld_r;
        res_inf_s = s1_inf_r;
        res_ovf_s = s1_ovf_r;
        res_op_s  = s1_op_r;
        case (state_r)
            ST_IDLE: res_op_s = s1_op_r;
            ST_ACCUM: begin
                res_val_s = m_val_s;
                res_idx_s = m_lane_s[0] ? s1_idx_r : acc_idx_r;
                res_vld_s = m_vld_s;
                res_inf_s = m_inf_s;
                res_ovf_s = acc_ovf_r | s1_ovf_r;
                res_op_s  = acc_op_r;
            end
            default: res_op_s = s1_op_r;
        endcase
    end

    // Accumulator registers, cleared when a vector completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_vld_r <= 1'b0;
            acc_inf_r <= 1'b0;
            acc_ovf_r <= 1'b0;
            acc_val_r <= {W{1'b0}};
            acc_idx_r <= {IDX_BITS{1'b0}};
            acc_op_r  <= OP_MAX;
        end else if (step_s) begin
            if (s1_last_r) begin
                acc_vld_r <= 1'b0;
                acc_inf_r <= 1'b0;
                acc_ovf_r <= 1'b0;
                acc_val_r <= {W{1'b0}};
                acc_idx_r <= {IDX_BITS{1'b0}};
                acc_op_r  <= OP_MAX;
            end else begin
                acc_vld_r <= res_vld_s;
                acc_inf_r <= res_inf_s;
                acc_ovf_r <= res_ovf_s;
                acc_val_r <= res_val_s;
                acc_idx_r <= res_idx_s;
                acc_op_r  <= res_op_s;
            end
        end
    end

    // Result register; a vector with no unmasked lanes reports empty with zeroed fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= {W{1'b0}};
            out_index    <= {IDX_BITS{1'b0}};
            out_inf      <= 1'b0;
            out_empty    <= 1'b0;
            out_overflow <= 1'b0;
        end else if (step_s && s1_last_r) begin
            out_valid    <= 1'b1;
            out_data     <= res_vld_s ? res_val_s : {W{1'b0}};
            out_index    <= res_vld_s ? res_idx_s : {IDX_BITS{1'b0}};
            out_inf      <= res_vld_s & res_inf_s;
            out_empty    <= !res_vld_s;
            out_overflow <= res_ovf_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_log_compare_reduce.sv
// Directed bench for log_compare_reduce: hand-computed expectations queued at stimulus
// time and compared as each result is consumed.
module tb_log_compare_reduce;
    import log_compare_reduce_pkg::*;

    localparam int M = 4, F = 4, LANES = 4, IDX_BITS = 4;
    localparam int W = M + F + 1;
    localparam logic [W-1:0] INF = 9'h07F;
    localparam logic [W-1:0] PZ  = 9'h080;
    localparam logic [W-1:0] NZ  = 9'h180;

    logic clock, reset;
    reduce_op_t op;
    logic in_valid, in_ready, in_last, out_valid, out_ready;
    logic [LANES*W-1:0] in_data;
    logic [LANES-1:0] in_lane_valid;
    logic [W-1:0] out_data;
    logic [IDX_BITS-1:0] out_index;
    logic out_inf, out_empty, out_overflow;

    log_compare_reduce #(.M(M), .F(F), .LANES(LANES), .IDX_BITS(IDX_BITS)) dut (
        .clock(clock), .reset(reset), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lane_valid(in_lane_valid), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_inf(out_inf), .out_empty(out_empty),
        .out_overflow(out_overflow)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [IDX_BITS-1:0] index;
        logic inf, empty, ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {sign, log2(|x|) * 16}
    function automatic logic [W-1:0] enc(input logic s, input int l16);
        return {s, l16[7:0]};
    endfunction

    function automatic logic [LANES*W-1:0] bt(input logic [W-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic push_exp(input logic [W-1:0] d, input int idx, input logic inf, empty, ovf);
        exp_t e;
        e.data = d; e.index = IDX_BITS'(idx); e.inf = inf; e.empty = empty; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic send_beat(input reduce_op_t o, input logic [LANES*W-1:0] d,
                             input logic [LANES-1:0] m, input logic l);
        int waited;
        waited = 0;
        op = o; in_data = d; in_lane_valid = m; in_last = l; in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clock); #1;
            waited++;
        end
        check("send_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    // Scoreboard: compare each result on the cycle it is consumed.
    always begin
        @(negedge clock); #2;
        if (!reset && out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.data));
                check("out_index", 32'(out_index), 32'(mon_e.index));
                check("out_inf", 32'(out_inf), 32'(mon_e.inf));
                check("out_empty", 32'(out_empty), 32'(mon_e.empty));
                check("out_overflow", 32'(out_overflow), 32'(mon_e.ovf));
            end
        end
    end

    initial begin
        reset = 1'b1; op = OP_MAX; in_valid = 1'b0; in_data = '0;
        in_lane_valid = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_flags", 32'({out_inf, out_empty, out_overflow}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single beat MAX with latency check
        push_exp(enc(1'b0, 32), 1, 1'b0, 1'b0, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 0), enc(1'b0, 32), enc(1'b1, 48), enc(1'b0, -16)), 4'hF, 1'b1);
        check("lat_edge0", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("lat_edge2", 32'(out_valid), 32'd1);
        drain();

        // MIN tie across beats; op change mid-vector ignored
        push_exp(enc(1'b1, 32), 1, 1'b0, 1'b0, 1'b0);
        send_beat(OP_MIN, bt(enc(1'b0, 16), enc(1'b1, 32), enc(1'b0, 0), enc(1'b0, 25)), 4'hF, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b1, 32), enc(1'b0, 37), enc(1'b0, 41), enc(1'b0, 45)), 4'hF, 1'b1);
        drain();

        // Inf sticky
        push_exp(INF, 1, 1'b1, 1'b0, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 0), INF, enc(1'b0, 48), enc(1'b0, 16)), 4'hF, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 64), INF, enc(1'b0, -16), enc(1'b0, 0)), 4'hF, 1'b1);
        drain();

        // Masking, then empty vector (masked inf ignored), back to back
        push_exp(enc(1'b1, 16), 2, 1'b0, 1'b0, 1'b0);
        push_exp(9'h000, 0, 1'b0, 1'b1, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 64), enc(1'b0, 64), enc(1'b1, 16), enc(1'b0, 64)), 4'b0100, 1'b1);
        send_beat(OP_MAX, bt(enc(1'b0, 64), INF, enc(1'b1, 16), enc(1'b0, 64)), 4'b0000, 1'b1);
        drain();

        // +0 and -0 compare equal: lower index wins
        push_exp(PZ, 0, 1'b0, 1'b0, 1'b0);
        push_exp(NZ, 1, 1'b0, 1'b0, 1'b0);
        send_beat(OP_MAX, bt(PZ, NZ, enc(1'b1, 0), enc(1'b1, 16)), 4'hF, 1'b1);
        send_beat(OP_MIN, bt(enc(1'b0, 0), NZ, PZ, enc(1'b0, 16)), 4'hF, 1'b1);
        drain();

        // Backpressure with two queued vectors
        out_ready = 1'b0;
        push_exp(enc(1'b0, 25), 2, 1'b0, 1'b0, 1'b0);
        push_exp(enc(1'b1, 16), 1, 1'b0, 1'b0, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 0), enc(1'b0, 16), enc(1'b0, 25), enc(1'b0, -16)), 4'hF, 1'b1);
        send_beat(OP_MIN, bt(enc(1'b0, 16), enc(1'b1, 16), enc(1'b0, 32), enc(1'b1, 16)), 4'hF, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_data", 32'(out_data), 32'(enc(1'b0, 25)));
            check("bp_hold_index", 32'(out_index), 32'd2);
            @(negedge clock);
        end
        out_ready = 1'b1;
        drain();

        // Exactly 16 positions: no overflow; then 5 beats: overflow and wrapped index
        push_exp(enc(1'b0, 48), 15, 1'b0, 1'b0, 1'b0);
        push_exp(enc(1'b0, 64), 1, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++)
            send_beat(OP_MAX, bt(enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0)), 4'hF, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 48)), 4'hF, 1'b1);
        for (int b = 0; b < 4; b++)
            send_beat(OP_MAX, bt(enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0)), 4'hF, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 0), enc(1'b0, 64), enc(1'b0, 0), enc(1'b0, 0)), 4'hF, 1'b1);
        drain();

        // Reset mid-vector discards in-flight state
        send_beat(OP_MAX, bt(enc(1'b0, 64), enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0)), 4'hF, 1'b0);
        send_beat(OP_MAX, bt(enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0), enc(1'b0, 0)), 4'hF, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("post_rst_no_output", 32'(out_valid), 32'd0);
        push_exp(enc(1'b0, 16), 1, 1'b0, 1'b0, 1'b0);
        send_beat(OP_MIN, bt(enc(1'b0, 25), enc(1'b0, 16), enc(1'b0, 32), enc(1'b0, 37)), 4'hF, 1'b1);
        drain();

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
